// File: rtl/xcorr_lag_search.sv
// Purpose: cross-correlates two sample buffers over lags -MAX_LAG..+MAX_LAG and reports the peak lag.
// Latency: (2*MAX_LAG+1)*(N_SAMPLES+4)+1 cycles from the clock that samples the start edge to done.
// Backpressure: none; drives the buffer read port itself, start edges while busy are dropped.
// Build option: define XCORR_ABS_EN to select the lag of largest |R(L)| instead of largest signed R(L).
module xcorr_lag_search #(
  parameter int ADDR_W    = 10,
  parameter int N_SAMPLES = 1024,
  parameter int MAX_LAG   = 31,
  parameter int LAG_W     = 8,
  parameter int ACC_W     = 46
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr_a,
  output logic [ADDR_W-1:0]        rd_addr_b,
  input  logic signed [17:0]       data_a,
  input  logic signed [17:0]       data_b,
  output logic                     busy,
  output logic                     done,
  output logic signed [LAG_W-1:0]  best_lag,
  output logic signed [ACC_W-1:0]  best_corr
);

  // Wide enough to hold n+lag without wrapping, so the range test sees the true sum.
  localparam int SUM_W = ADDR_W + LAG_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  state_t                   state;
  logic                     start_d;
  logic                     start_edge;
  logic [ADDR_W-1:0]        n;
  logic signed [LAG_W-1:0]  lag;
  logic [1:0]               drain_cnt;
  logic signed [LAG_W-1:0]  best_lag_r;
  logic signed [ACC_W-1:0]  best_corr_r;
  logic signed [SUM_W-1:0]  addr_sum;
  logic                     pair_ok;
  logic                     better;

  // Pipeline: v0 rides with the issued address, v1 with RAM data, v2 with the product.
  logic                     v0;
  logic                     v1;
  logic                     v2;
  logic signed [35:0]       prod;
  logic signed [ACC_W-1:0]  acc;

  assign start_edge = start & ~start_d;
  assign addr_sum   = SUM_W'(n) + SUM_W'(lag);
  assign pair_ok    = (addr_sum >= 0) && (addr_sum <= SUM_W'(N_SAMPLES - 1));

`ifdef XCORR_ABS_EN
  // One extra bit so the most negative accumulator value has a representable magnitude.
  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] best_x;
  logic [ACC_W:0]        acc_mag;
  logic [ACC_W:0]        best_mag;

  assign acc_x    = (ACC_W+1)'(acc);
  assign best_x   = (ACC_W+1)'(best_corr_r);
  assign acc_mag  = acc_x[ACC_W]  ? -acc_x  : acc_x;
  assign best_mag = best_x[ACC_W] ? -best_x : best_x;
  assign better   = acc_mag > best_mag;
`else
  assign better   = acc > best_corr_r;
`endif

  // Data path: RAM return alignment and registered product; invalid pairs yield a zero product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      prod <= '0;
    end else begin
      v1 <= v0;
      v2 <= v1;
      if (v1) begin
        prod <= 36'(data_a) * 36'(data_b);
      end else begin
        prod <= '0;
      end
    end
  end

  // Control FSM: address issue, lag sequencing, running maximum and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_d     <= 1'b0;
      n           <= '0;
      lag         <= '0;
      drain_cnt   <= '0;
      rd_en       <= 1'b0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      v0          <= 1'b0;
      acc         <= '0;
      best_lag_r  <= '0;
      best_corr_r <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_lag    <= '0;
      best_corr   <= '0;
    end else begin
      start_d <= start;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            lag   <= LAG_W'(-MAX_LAG);
            n     <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          rd_en     <= 1'b1;
          rd_addr_a <= n;
          rd_addr_b <= addr_sum[ADDR_W-1:0];
          v0        <= pair_ok;
          if (n == ADDR_W'(N_SAMPLES - 1)) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            n <= n + ADDR_W'(1);
          end
        end

        S_DRAIN: begin
          rd_en <= 1'b0;
          v0    <= 1'b0;
          if (drain_cnt == 2'd2) begin
            state <= S_CMP;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end

        S_CMP: begin
          // Strict compare: on ties the earlier (more negative) lag is kept.
          if (lag == LAG_W'(-MAX_LAG) || better) begin
            best_corr_r <= acc;
            best_lag_r  <= lag;
          end
          acc <= '0;
          if (lag == LAG_W'(MAX_LAG)) begin
            state <= S_DONE;
          end else begin
            lag   <= lag + LAG_W'(1);
            n     <= '0;
            state <= S_RUN;
          end
        end

        S_DONE: begin
          done      <= 1'b1;
          best_lag  <= best_lag_r;
          best_corr <= best_corr_r;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // The pipeline is empty during CMP, so the clear there never races an add.
      if (state != S_CMP && v2) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

endmodule
